// File: rtl/counter_arb.sv
// counter_arb: round-robin owner of one shared counter_up instance.
// Grants one of two requesters, holds the counter in clear while free,
// and pulses done to the owner once the counter reaches its latched limit.
// Ports:
//   clk, clr (async active-high reset)
//   req[1:0]          request levels, held until done or abandoned
//   lim0, lim1 [N-1:0] per-requester interval limits, sampled on grant
//   cnt [N-1:0]       shared counter value
//   cnt_clr           registered clear for the shared counter
//   gnt[1:0]          one-hot owner, 00 when free
//   done[1:0]         one-cycle completion pulse to the owner
//   busy              high in RUN and DONE
module counter_arb #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [1:0]   req,
  input  logic [N-1:0] lim0,
  input  logic [N-1:0] lim1,
  input  logic [N-1:0] cnt,
  output logic         cnt_clr,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state, state_d;
  logic [N-1:0] lim_q, lim_d;
  logic         last, last_d;
  logic [1:0]   gnt_d, done_d;
  logic         busy_d, cnt_clr_d;
  logic         win;
  logic         owner;

  // State and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= S_IDLE;
      gnt     <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
      cnt_clr <= 1'b1;
      lim_q   <= '0;
      last    <= 1'b1;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= busy_d;
      cnt_clr <= cnt_clr_d;
      lim_q   <= lim_d;
      last    <= last_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    done_d    = 2'b00;
    busy_d    = busy;
    cnt_clr_d = cnt_clr;
    lim_d     = lim_q;
    last_d    = last;
    win       = 1'b0;
    owner     = gnt[1];

    case (state)
      S_IDLE: begin
        gnt_d     = 2'b00;
        cnt_clr_d = 1'b1;
        busy_d    = 1'b0;
        if (req != 2'b00) begin
          // Tie goes to the requester not served last
          win       = (req == 2'b11) ? ~last : req[1];
          state_d   = S_RUN;
          gnt_d     = win ? 2'b10 : 2'b01;
          lim_d     = win ? lim1 : lim0;
          last_d    = win;
          cnt_clr_d = 1'b0;
          busy_d    = 1'b1;
        end
      end

      S_RUN: begin
        // Abort takes priority over a limit match
        if (!req[owner]) begin
          state_d   = S_IDLE;
          gnt_d     = 2'b00;
          cnt_clr_d = 1'b1;
          busy_d    = 1'b0;
        end else if (cnt == lim_q) begin
          state_d   = S_DONE;
          done_d    = owner ? 2'b10 : 2'b01;
          gnt_d     = 2'b00;
          cnt_clr_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        gnt_d     = 2'b00;
        cnt_clr_d = 1'b1;
        busy_d    = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        gnt_d     = 2'b00;
        cnt_clr_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_arb.sv
// Self-checking bench for counter_arb with a behavioural counter_up model.
module tb_counter_arb;

  localparam int unsigned N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [N-1:0] lim0, lim1;
  logic [N-1:0] cnt;
  logic         cnt_clr;
  logic [1:0]   gnt, done;
  logic         busy;

  int nvec = 0;
  int nerr = 0;

  // Reference state: owner index (-1 free), cycles left before match,
  // cycles elapsed in the run, requester in its done cycle, last winner.
  int m_own, m_rem, m_el, m_done, m_last;

  counter_arb #(.N(N)) dut (
    .clk     (clk),
    .clr     (rst),
    .req     (req),
    .lim0    (lim0),
    .lim1    (lim1),
    .cnt     (cnt),
    .cnt_clr (cnt_clr),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Shared counter_up instance
  always @(posedge clk or posedge cnt_clr) begin
    if (cnt_clr) cnt <= '0;
    else         cnt <= cnt + 1'b1;
  end

  task automatic cmp(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_rem = 0; m_el = 0; m_done = -1; m_last = 1;
  endtask

  // Advance the reference by one clock using the current inputs
  task automatic model_update();
    int w;
    if (m_done >= 0) begin
      m_done = -1;
    end else if (m_own < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) w = 1 - m_last;
        else              w = req[1] ? 1 : 0;
        m_own  = w;
        m_last = w;
        m_rem  = (w == 1) ? int'(lim1) : int'(lim0);
        m_el   = 0;
      end
    end else if (!req[m_own]) begin
      m_own = -1;
    end else if (m_rem == 0) begin
      m_done = m_own;
      m_own  = -1;
    end else begin
      m_rem--;
      m_el++;
    end
  endtask

  task automatic check_model();
    cmp("gnt",     int'(gnt),     (m_own  < 0) ? 0 : (1 << m_own));
    cmp("done",    int'(done),    (m_done < 0) ? 0 : (1 << m_done));
    cmp("busy",    int'(busy),    (m_own >= 0 || m_done >= 0) ? 1 : 0);
    cmp("cnt_clr", int'(cnt_clr), (m_own >= 0) ? 0 : 1);
    if (m_own >= 0) cmp("cnt", int'(cnt), m_el);
  endtask

  // One clock: update the model, let the edge pass, compare at the negedge
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [1:0]   req;
    logic [N-1:0] lim0;
    logic [N-1:0] lim1;
    logic [1:0]   exp_gnt;
    int           exp_len;
  } vec_t;

  vec_t vt[8];

  initial begin
    // Directed intervals; tie rows depend on the order of the table
    vt[0] = '{2'b11, 3'd1, 3'd2, 2'b01, 2};
    vt[1] = '{2'b11, 3'd1, 3'd2, 2'b10, 3};
    vt[2] = '{2'b11, 3'd1, 3'd2, 2'b01, 2};
    vt[3] = '{2'b11, 3'd1, 3'd2, 2'b10, 3};
    vt[4] = '{2'b01, 3'd3, 3'd6, 2'b01, 4};
    vt[5] = '{2'b10, 3'd5, 3'd0, 2'b10, 1};
    vt[6] = '{2'b01, 3'd7, 3'd1, 2'b01, 8};
    vt[7] = '{2'b11, 3'd4, 3'd2, 2'b10, 3};

    rst = 1'b1; req = 2'b00; lim0 = '0; lim1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp("rst_gnt",     int'(gnt),     0);
    cmp("rst_done",    int'(done),    0);
    cmp("rst_busy",    int'(busy),    0);
    cmp("rst_cnt_clr", int'(cnt_clr), 1);
    cmp("rst_cnt",     int'(cnt),     0);
    rst = 1'b0;
    step();

    // Table-driven intervals
    for (int i = 0; i < 8; i++) begin
      int len;
      int k;
      req = vt[i].req; lim0 = vt[i].lim0; lim1 = vt[i].lim1;
      step();
      k = 0;
      while (gnt == 2'b00 && k < 4) begin step(); k++; end
      cmp("tbl_gnt", int'(gnt), int'(vt[i].exp_gnt));
      len = 0;
      while (gnt != 2'b00 && len < 20) begin len++; step(); end
      cmp("tbl_len",  len, vt[i].exp_len);
      cmp("tbl_done", int'(done), int'(vt[i].exp_gnt));
      req = 2'b00;
      step();
      cmp("tbl_idle", int'(busy), 0);
    end

    // Abort after two RUN cycles with requester 1 waiting
    req = 2'b01; lim0 = 3'd5; lim1 = 3'd2;
    step();
    cmp("abort_gnt0", int'(gnt), 1);
    step(); step();
    req = 2'b10;
    step();
    cmp("abort_gnt",     int'(gnt),     0);
    cmp("abort_cnt_clr", int'(cnt_clr), 1);
    cmp("abort_done",    int'(done),    0);
    step();
    cmp("abort_next", int'(gnt), 2);
    req = 2'b00;
    repeat (5) step();

    // Reset pulse in the middle of a run
    req = 2'b01; lim0 = 3'd6;
    step(); step(); step();
    #1 rst = 1'b1;
    #1;
    cmp("mid_gnt",     int'(gnt),     0);
    cmp("mid_done",    int'(done),    0);
    cmp("mid_busy",    int'(busy),    0);
    cmp("mid_cnt_clr", int'(cnt_clr), 1);
    model_reset();
    #4 rst = 1'b0;
    req = 2'b11; lim0 = 3'd2; lim1 = 3'd3;
    @(negedge clk);
    check_model();
    step();
    cmp("mid_first", int'(gnt), 1);
    req = 2'b00;
    repeat (6) step();

    // Randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) req = 2'($urandom_range(3));
      lim0 = N'($urandom);
      lim1 = N'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
